madd_error_monitor: RTL and testbench
=====================================

Name: madd_error_monitor

Overview:
- Sequential exhaustive checker that sits on the far side of an approximate 6-input/4-output multiply-add netlist.
- Sweeps all 64 input vectors into the circuit under test and samples its 4-bit result.
- Compares each sample against the exact function out = a*b + c, where a = in[1:0], b = in[3:2], c = in[5:4].
- Accumulates error statistics and reports pass/fail against the error threshold used when the netlist was synthesised.

Parameters:
- ET, 2, maximum allowed absolute error; pass requires max_err <= ET.
- SETTLE, 1, idle cycles approx_in is held before approx_out is sampled (0..15).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; honoured only in IDLE or DONE.
- abort  input  1  stop a sweep in progress.
- approx_in  output  6  vector driven to the circuit under test (in5..in0 packed as [5:0]).
- approx_out  input  4  circuit-under-test result (out3..out0 packed as [3:0]); combinational from approx_in.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  valid in DONE; 1 when max_err <= ET.
- max_err  output  4  largest |exact - approx| seen.
- err_count  output  7  number of vectors with nonzero error (0..64).
- sum_err  output  10  sum of |exact - approx| over the sweep (max 960).
- first_fail_vec  output  6  lowest vector index with nonzero error.
- first_fail_valid  output  1  first_fail_vec holds a real value.

Behaviour:
- Reset (async, any time): state IDLE; all outputs 0, including approx_in; settle counter 0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE/DONE + start:
  - clear all statistics, pass, first_fail_*.
  - approx_in = 0, settle counter = SETTLE, busy = 1.
  - Next state is DRIVE if SETTLE > 0, otherwise SAMPLE.
- DRIVE: decrement settle counter each cycle; go to SAMPLE when it reaches 1.
- SAMPLE, evaluated in the same cycle from the current approx_in and approx_out:
  - exact = a*b + c, 4-bit.
  - e = |exact - approx_out|, 4-bit unsigned; approx_out values 13..15 are legal and give e up to 15.
  - Update max_err, sum_err, and err_count (if e != 0).
  - If e != 0 and first_fail_valid = 0: load first_fail_vec and set first_fail_valid.
- SAMPLE, not last vector: approx_in increments, settle counter reloads, next state DRIVE (or SAMPLE if SETTLE = 0).
- SAMPLE, last vector (approx_in = 63):
  - next state DONE; busy = 0; done pulses for exactly one cycle.
  - pass is registered from the final max_err; approx_in returns to 0. No wrap to a second sweep.
- Timing: each vector takes SETTLE+1 cycles. start is sampled at edge 0; done is high during cycle 64*(SETTLE+1)+1.
- DONE: results and pass are held until the next start or reset; done stays low.
- abort while busy:
  - next state IDLE; busy = 0; approx_in = 0; no done pulse; pass = 0.
  - Partial statistics remain frozen for debug.
- abort in IDLE/DONE: ignored.
- abort and start in the same cycle: abort wins when busy; start wins when idle.
- start while busy: ignored; the sweep is not restarted.
- Statistics registers saturate by construction (widths cover worst case); no overflow handling required.

Test Plan:
- Exact model connected as the circuit under test, SETTLE = 1, pulse start:
  - done after 129 cycles.
  - max_err = 0, err_count = 0, sum_err = 0, first_fail_valid = 0, pass = 1.
- approx_out tied to 0:
  - max_err = 12, err_count = 57, sum_err = 240.
  - first_fail_vec = 5, first_fail_valid = 1, pass = 0 (ET = 2).
- approx_out = exact + 1:
  - max_err = 1, err_count = 64, sum_err = 64.
  - first_fail_vec = 0, pass = 1.
- SETTLE = 0, exact model:
  - approx_in advances every cycle 0..63.
  - done on cycle 65; busy low same cycle; approx_in back to 0.
- abort asserted when approx_in = 10:
  - IDLE next cycle, busy = 0, no done pulse, pass = 0.
  - A following start runs a full clean sweep with the statistics cleared.
- Async rst mid-sweep (approx_in = 30, between clock edges):
  - all outputs 0 immediately.
  - start pulsed during rst is ignored.
  - start pulsed while busy (approx_in = 20) does not restart the sweep.

Source files
------------

// File: rtl/madd_error_monitor.sv
// rtl/madd_error_monitor.sv - exhaustive error monitor for an approximate a*b+c netlist
module madd_error_monitor #(
  parameter int ET     = 2,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [5:0] approx_in,
  input  logic [3:0] approx_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] max_err,
  output logic [6:0] err_count,
  output logic [9:0] sum_err,
  output logic [5:0] first_fail_vec,
  output logic       first_fail_valid
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_L = SETTLE[3:0];
  localparam logic [3:0] ET_L     = ET[3:0];
  // With no settle time every vector is sampled in the cycle it is driven.
  localparam logic [1:0] S_FIRST  = (SETTLE == 0) ? S_SAMPLE : S_DRIVE;

  logic [1:0] r_state;
  logic [3:0] r_settle;
  logic [5:0] r_in;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_max;
  logic [6:0] r_cnt;
  logic [9:0] r_sum;
  logic [5:0] r_ff_vec;
  logic       r_ff_valid;

  logic [3:0] w_a;
  logic [3:0] w_b;
  logic [3:0] w_c;
  logic [3:0] w_exact;
  logic [3:0] w_err;
  logic       w_nz;
  logic [3:0] w_max_next;
  logic [9:0] w_sum_next;
  logic [6:0] w_cnt_next;
  logic       w_last;

  // Reference result and absolute error for the vector currently on approx_in.
  always_comb begin
    w_a        = {2'b00, r_in[1:0]};
    w_b        = {2'b00, r_in[3:2]};
    w_c        = {2'b00, r_in[5:4]};
    w_exact    = (w_a * w_b) + w_c;
    w_err      = (w_exact >= approx_out) ? (w_exact - approx_out) : (approx_out - w_exact);
    w_nz       = (w_err != 4'd0);
    w_max_next = (w_err > r_max) ? w_err : r_max;
    w_sum_next = r_sum + {6'b000000, w_err};
    w_cnt_next = r_cnt + {6'b000000, w_nz};
    w_last     = (r_in == 6'd63);
  end

  // Sweep sequencer and statistics accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_settle   <= 4'd0;
      r_in       <= 6'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_max      <= 4'd0;
      r_cnt      <= 7'd0;
      r_sum      <= 10'd0;
      r_ff_vec   <= 6'd0;
      r_ff_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_max      <= 4'd0;
            r_cnt      <= 7'd0;
            r_sum      <= 10'd0;
            r_ff_vec   <= 6'd0;
            r_ff_valid <= 1'b0;
            r_pass     <= 1'b0;
            r_in       <= 6'd0;
            r_settle   <= SETTLE_L;
            r_busy     <= 1'b1;
            r_state    <= S_FIRST;
          end
        end
        S_DRIVE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_in    <= 6'd0;
            r_pass  <= 1'b0;
          end else begin
            r_settle <= r_settle - 4'd1;
            if (r_settle <= 4'd1) begin
              r_state <= S_SAMPLE;
            end
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            // Statistics gathered so far are left untouched for debug.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_in    <= 6'd0;
            r_pass  <= 1'b0;
          end else begin
            r_max <= w_max_next;
            r_sum <= w_sum_next;
            r_cnt <= w_cnt_next;
            if (w_nz && !r_ff_valid) begin
              r_ff_vec   <= r_in;
              r_ff_valid <= 1'b1;
            end
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_max_next <= ET_L);
              r_in    <= 6'd0;
            end else begin
              r_in     <= r_in + 6'd1;
              r_settle <= SETTLE_L;
              r_state  <= S_FIRST;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_in    <= 6'd0;
        end
      endcase
    end
  end

  assign approx_in        = r_in;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign max_err          = r_max;
  assign err_count        = r_cnt;
  assign sum_err          = r_sum;
  assign first_fail_vec   = r_ff_vec;
  assign first_fail_valid = r_ff_valid;

endmodule

// File: tb/tb_madd_error_monitor.sv
// tb/tb_madd_error_monitor.sv - directed bench for madd_error_monitor
module tb_madd_error_monitor;

  logic       clk;
  logic       rst;
  logic       start1, abort1, start0, abort0;
  logic [5:0] ai1, ai0;
  logic [3:0] ao1, ao0;
  logic       busy1, done1, pass1, busy0, done0, pass0;
  logic [3:0] max1, max0;
  logic [6:0] cnt1, cnt0;
  logic [9:0] sum1, sum0;
  logic [5:0] ffv1, ffv0;
  logic       ffok1, ffok0;
  int         m1;
  int         n_checks;
  int         n_errors;

  madd_error_monitor #(.ET(2), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .approx_in(ai1), .approx_out(ao1), .busy(busy1), .done(done1), .pass(pass1),
    .max_err(max1), .err_count(cnt1), .sum_err(sum1),
    .first_fail_vec(ffv1), .first_fail_valid(ffok1)
  );

  madd_error_monitor #(.ET(2), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0),
    .approx_in(ai0), .approx_out(ao0), .busy(busy0), .done(done0), .pass(pass0),
    .max_err(max0), .err_count(cnt0), .sum_err(sum0),
    .first_fail_vec(ffv0), .first_fail_valid(ffok0)
  );

  // Circuit-under-test model: 0 exact, 1 constant zero, 2 exact plus one
  function automatic logic [3:0] cut(input logic [5:0] v, input int mode);
    logic [3:0] a, b, c, ex;
    a  = {2'b00, v[1:0]};
    b  = {2'b00, v[3:2]};
    c  = {2'b00, v[5:4]};
    ex = a * b + c;
    if (mode == 1) return 4'd0;
    if (mode == 2) return ex + 4'd1;
    return ex;
  endfunction

  always_comb ao1 = cut(ai1, m1);
  always_comb ao0 = cut(ai0, 0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start1;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
  endtask

  task automatic wait_done1(output int n);
    n = 1;
    while (!done1 && n < 400) begin
      tick;
      n++;
    end
  endtask

  task automatic wait_vec1(input logic [5:0] v, input string tag);
    int k;
    k = 0;
    while (ai1 !== v && k < 200) begin
      tick;
      k++;
    end
    chk(tag, ai1, v);
  endtask

  initial begin
    int n;
    int bad;
    int seen;
    int inj;
    n_checks = 0;
    n_errors = 0;
    m1 = 0;
    rst = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; start0 = 1'b0; abort0 = 1'b0;
    tick;
    tick;
    chk("reset_approx_in", ai1, 0);
    chk("reset_busy", busy1, 0);
    chk("reset_done", done1, 0);
    chk("reset_pass", pass1, 0);
    chk("reset_ffvalid", ffok1, 0);
    rst = 1'b0;
    tick;

    // Exact circuit: clean sweep
    pulse_start1;
    chk("busy_after_start", busy1, 1);
    wait_done1(n);
    chk("exact_latency", n, 129);
    chk("exact_max", max1, 0);
    chk("exact_cnt", cnt1, 0);
    chk("exact_sum", sum1, 0);
    chk("exact_ffvalid", ffok1, 0);
    chk("exact_pass", pass1, 1);
    chk("exact_busy_done", busy1, 0);
    chk("exact_in_back0", ai1, 0);
    tick;
    chk("exact_done_one_cycle", done1, 0);
    chk("exact_pass_held", pass1, 1);

    // Output stuck at zero
    m1 = 1;
    pulse_start1;
    wait_done1(n);
    chk("zero_latency", n, 129);
    chk("zero_max", max1, 12);
    chk("zero_cnt", cnt1, 57);
    chk("zero_sum", sum1, 240);
    chk("zero_ffvec", ffv1, 5);
    chk("zero_ffvalid", ffok1, 1);
    chk("zero_pass", pass1, 0);

    // Output off by one everywhere
    m1 = 2;
    pulse_start1;
    wait_done1(n);
    chk("plus1_latency", n, 129);
    chk("plus1_max", max1, 1);
    chk("plus1_cnt", cnt1, 64);
    chk("plus1_sum", sum1, 64);
    chk("plus1_ffvec", ffv1, 0);
    chk("plus1_ffvalid", ffok1, 1);
    chk("plus1_pass", pass1, 1);

    // SETTLE = 0: one vector per cycle
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    bad = 0;
    for (int k = 1; k <= 64; k++) begin
      if (ai0 !== 6'(k - 1) || done0 !== 1'b0 || busy0 !== 1'b1) bad++;
      tick;
    end
    chk("s0_sequence", bad, 0);
    chk("s0_done", done0, 1);
    chk("s0_busy", busy0, 0);
    chk("s0_in_back0", ai0, 0);
    chk("s0_pass", pass0, 1);
    chk("s0_max", max0, 0);

    // Abort mid-sweep
    m1 = 1;
    pulse_start1;
    wait_vec1(6'd10, "abort_reach10");
    abort1 = 1'b1;
    tick;
    abort1 = 1'b0;
    chk("abort_busy", busy1, 0);
    chk("abort_in", ai1, 0);
    chk("abort_pass", pass1, 0);
    chk("abort_partial_cnt", cnt1, 4);
    chk("abort_partial_ffvec", ffv1, 5);
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      if (done1 || busy1) seen++;
      tick;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_frozen_cnt", cnt1, 4);
    m1 = 0;
    pulse_start1;
    wait_done1(n);
    chk("post_abort_latency", n, 129);
    chk("post_abort_cnt", cnt1, 0);
    chk("post_abort_sum", sum1, 0);
    chk("post_abort_ffvalid", ffok1, 0);
    chk("post_abort_pass", pass1, 1);

    // Async reset mid-sweep
    m1 = 1;
    pulse_start1;
    wait_vec1(6'd30, "rst_reach30");
    #2;
    rst = 1'b1;
    #1;
    chk("arst_in", ai1, 0);
    chk("arst_busy", busy1, 0);
    chk("arst_max", max1, 0);
    chk("arst_cnt", cnt1, 0);
    chk("arst_sum", sum1, 0);
    chk("arst_ffvec", ffv1, 0);
    chk("arst_ffvalid", ffok1, 0);
    chk("arst_pass", pass1, 0);
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    tick;
    chk("start_in_rst_busy", busy1, 0);
    rst = 1'b0;
    tick;
    chk("start_in_rst_idle", busy1, 0);
    chk("start_in_rst_in", ai1, 0);

    // start while busy must not restart
    m1 = 0;
    pulse_start1;
    n = 1;
    inj = 0;
    while (!done1 && n < 400) begin
      if (inj == 0 && ai1 == 6'd20) begin
        start1 = 1'b1;
        inj = 1;
        tick;
        start1 = 1'b0;
      end else begin
        tick;
      end
      n++;
    end
    chk("busy_start_injected", inj, 1);
    chk("busy_start_latency", n, 129);
    chk("busy_start_cnt", cnt1, 0);
    chk("busy_start_pass", pass1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
